fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of `pipelined_machine`, covering the path from the PC register through to the IF/ID pipeline register. It drives the word address into instruction memory and captures the returned instruction with PC+4. It honours stall and flush from the hazard unit and redirect from branch/jump resolution. Downstream, the decode stage consumes `id_inst`/`id_pc4`/`id_valid`.

## Interface
- `RESET_PC`, 32'h00400000, fetch address loaded on reset; bits [1:0] ignored.
- `NOP_INST`, 32'h00000000, instruction word inserted into IF/ID on reset or flush.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-low; the block is in reset on any rising edge where `reset`==0.
- `stall`  in  1  hazard hold; freezes PC and IF/ID.
- `flush`  in  1  replaces the IF/ID contents with a bubble on the next edge.
- `redirect_valid`  in  1  branch/jump taken this cycle.
- `redirect_pc`  in  32  target byte address; bits [1:0] dropped.
- `imem_addr`  out  30  word address to instruction memory (= `pc`[31:2]).
- `imem_data`  in  32  combinational instruction read for `imem_addr`, same cycle.
- `pc`  out  32  current fetch PC, bits [1:0] always 0.
- `id_inst`  out  32  IF/ID instruction.
- `id_pc4`  out  32  IF/ID PC+4 of that instruction.
- `id_valid`  out  1  IF/ID holds a real instruction (0 = bubble).
- `fetch_count`  out  32  present only with the configuration macro.
- `stall_count`  out  32  present only with the configuration macro.

## Operation
- The PC is held internally as a 30-bit word address (`pc_q`); `pc` = {`pc_q`,2'b00}.
- PC next-state, in priority order:
  - reset → `RESET_PC`[31:2]
  - `redirect_valid` → `redirect_pc`[31:2]
  - `stall` → hold
  - otherwise → `pc_q`+1
- IF/ID next-state, in priority order:
  - reset → {`NOP_INST`, 0, valid=0}
  - `flush` → {`NOP_INST`, 0, valid=0}
  - `stall` → hold
  - otherwise → {`imem_data`, `pc`+4, valid=1}
- Redirect overrides stall for the PC. Flush overrides stall for IF/ID. The hazard unit asserts `flush` together with `redirect_valid` when the wrong-path instruction must be killed; `fetch_stage` does not infer it.
- PC increment wraps modulo 2^30 words: 0xFFFFFFFC → 0x00000000, and `id_pc4` = 0x00000000 in that case.
- `imem_addr` is purely a function of `pc_q`, with no combinational path from any input.

## Timing
- Reset values: `pc`=`RESET_PC`&~3, `imem_addr`=`RESET_PC`[31:2], `id_inst`=`NOP_INST`, `id_pc4`=0, `id_valid`=0, counters=0.
- Reset mid-operation takes effect at the next edge and overrides stall, flush and redirect.
- Fetch latency is 1 cycle: the instruction at `pc` in cycle N appears on `id_inst` after edge N+1.
- Redirect asserted in cycle N gives `pc`=target after edge N+1; the target instruction is in IF/ID after edge N+2.
- Stall held for K cycles freezes both PC and IF/ID for exactly K edges; no instruction is lost or duplicated.
- `flush` and `stall` together: IF/ID becomes a bubble while the PC is held, unless `redirect_valid` is also asserted.

## Configuration
- `FETCH_PERF_EN`: when defined, the ports `fetch_count` and `stall_count` exist.
  - `fetch_count` increments on every edge that loads a valid instruction into IF/ID.
  - `stall_count` increments on every edge with `stall`=1 and no reset.
  - Both counters wrap at 2^32.
- When `FETCH_PERF_EN` is undefined, the ports and counters are absent and the block's behaviour is otherwise identical.

## Structure
- Shared package `mips_pkg`:
  - `NOP_INST` and default `RESET_PC` constants
  - `WORD_ADDR_W`=30
  - a typedef for the IF/ID bundle {inst, pc4, valid}
- One sub-module, `if_id_reg`, holds the IF/ID bundle with priority reset > flush > stall > load. The decode/execute boundary registers reuse it.

## Test plan
- Release reset with `imem_data` returning 0x20080005 → `pc`=0x00400000 at reset; after 1 edge `id_inst`=0x20080005, `id_pc4`=0x00400004, `id_valid`=1, `pc`=0x00400004.
- Assert `stall` for 3 cycles at `pc`=0x00400008 → `pc` and IF/ID unchanged for 3 edges, then sequential fetch resumes from 0x00400008.
- Assert `redirect_valid` with `redirect_pc`=0x00400023 and `flush` together → next `pc`=0x00400020, `id_valid`=0, `id_inst`=0; the following edge loads the target instruction.
- Assert `redirect_valid`+`stall` together → `pc` takes the target and IF/ID holds; `flush`+`stall` together → IF/ID bubble with `pc` held.
- Force `pc` to 0xFFFFFFFC via redirect, then fetch sequentially → next `pc`=0x00000000 and `id_pc4`=0x00000000. Drive `reset`=0 mid-stall → all outputs return to reset values on the next edge.
- With `FETCH_PERF_EN` defined: 10 free-running edges, 4 stall edges and 1 flush edge → `fetch_count`=10, `stall_count`=4.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: constants and types shared by the pipelined_machine stages.
//   NOP_INST     instruction word used for pipeline bubbles
//   RESET_PC_DEF default fetch address after reset
//   WORD_ADDR_W  width of a word-granular instruction address
//   if_id_t      IF/ID bundle {inst, pc4, valid}
package mips_pkg;

  localparam int          WORD_ADDR_W  = 30;
  localparam logic [31:0] NOP_INST     = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEF = 32'h0040_0000;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc4;
    logic        valid;
  } if_id_t;

endpackage

// File: rtl/if_id_reg.sv
// if_id_reg: pipeline register holding one {inst, pc4, valid} bundle.
// Priority: reset > flush > stall > load. Reset and flush both insert a bubble.
//   clk    rising-edge clock
//   reset  synchronous, active-low
//   flush  load a bubble on the next edge
//   stall  hold current contents
//   d      bundle to load when neither flush nor stall
//   q      registered bundle
module if_id_reg
  import mips_pkg::*;
#(
  parameter logic [31:0] NOP = mips_pkg::NOP_INST
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   flush,
  input  logic   stall,
  input  if_id_t d,
  output if_id_t q
);

  localparam if_id_t BUBBLE = '{inst: NOP, pc4: 32'h0, valid: 1'b0};

  always_ff @(posedge clk) begin
    if (!reset)      q <= BUBBLE;
    else if (flush)  q <= BUBBLE;
    else if (!stall) q <= d;
  end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch from PC register to the IF/ID register.
// Build option: define FETCH_PERF_EN to add fetch_count / stall_count.
//   clk, reset        clock, synchronous active-low reset
//   stall             freeze PC and IF/ID
//   flush             bubble into IF/ID on next edge
//   redirect_valid/pc taken branch/jump target (byte address, [1:0] dropped)
//   imem_addr/data    word address out, combinational instruction in
//   pc                current fetch PC (byte address)
//   id_inst/pc4/valid IF/ID contents for decode
//   fetch_count       (FETCH_PERF_EN) edges loading a valid instruction
//   stall_count       (FETCH_PERF_EN) edges with stall out of reset
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = mips_pkg::RESET_PC_DEF,
  parameter logic [31:0] NOP_INST = mips_pkg::NOP_INST
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stall,
  input  logic                   flush,
  input  logic                   redirect_valid,
  input  logic [31:0]            redirect_pc,
  output logic [WORD_ADDR_W-1:0] imem_addr,
  input  logic [31:0]            imem_data,
  output logic [31:0]            pc,
  output logic [31:0]            id_inst,
  output logic [31:0]            id_pc4,
  output logic                   id_valid
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]            fetch_count,
  output logic [31:0]            stall_count
`endif
);

  logic [WORD_ADDR_W-1:0] pc_q;
  logic [WORD_ADDR_W-1:0] pc_inc;
  if_id_t                 ifid_d, ifid_q;

  // byte-offset bits of the target are don't-care
  logic unused_redirect_lsb;
  assign unused_redirect_lsb = ^redirect_pc[1:0];

  // word-granular increment wraps naturally at 2^30
  assign pc_inc = pc_q + 1'b1;

  // redirect wins over stall so a taken branch is never lost while stalled
  always_ff @(posedge clk) begin
    if (!reset)              pc_q <= RESET_PC[31:2];
    else if (redirect_valid) pc_q <= redirect_pc[31:2];
    else if (!stall)         pc_q <= pc_inc;
  end

  assign pc        = {pc_q, 2'b00};
  assign imem_addr = pc_q;

  always_comb begin
    ifid_d       = '0;
    ifid_d.inst  = imem_data;
    ifid_d.pc4   = {pc_inc, 2'b00};
    ifid_d.valid = 1'b1;
  end

  if_id_reg #(.NOP(NOP_INST)) u_if_id (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .stall (stall),
    .d     (ifid_d),
    .q     (ifid_q)
  );

  assign id_inst  = ifid_q.inst;
  assign id_pc4   = ifid_q.pc4;
  assign id_valid = ifid_q.valid;

`ifdef FETCH_PERF_EN
  // a valid load happens exactly when IF/ID takes the load branch
  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_count <= '0;
      stall_count <= '0;
    end else begin
      if (!flush && !stall) fetch_count <= fetch_count + 32'd1;
      if (stall)            stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset, stall, flush, redirect_valid;
  logic [31:0] redirect_pc;
  logic [29:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] pc, id_inst, id_pc4;
  logic        id_valid;
`ifdef FETCH_PERF_EN
  logic [31:0] fetch_count, stall_count;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // instruction memory image: a fixed word at the reset vector, a pattern elsewhere
  function automatic logic [31:0] inst_of(input logic [31:0] byte_addr);
    if (byte_addr[31:2] == 30'h0010_0000) return 32'h2008_0005;
    return {byte_addr[31:2], 2'b10} ^ 32'hA5A5_0000;
  endfunction

  assign imem_data = inst_of({imem_addr, 2'b00});

  fetch_stage dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .flush          (flush),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .pc             (pc),
    .id_inst        (id_inst),
    .id_pc4         (id_pc4),
    .id_valid       (id_valid)
`ifdef FETCH_PERF_EN
    ,
    .fetch_count    (fetch_count),
    .stall_count    (stall_count)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_ifid(input string tag, input logic [31:0] epc,
                            input logic [31:0] einst, input logic [31:0] epc4,
                            input logic evalid);
    check({tag, ".pc"},    pc,               epc);
    check({tag, ".inst"},  id_inst,          einst);
    check({tag, ".pc4"},   id_pc4,           epc4);
    check({tag, ".valid"}, {31'b0, id_valid}, {31'b0, evalid});
  endtask

  initial begin
    reset = 1'b0; stall = 1'b0; flush = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'h0;
    #2;
    step();
    check_ifid("rst", 32'h0040_0000, 32'h0, 32'h0, 1'b0);
    check("rst.imem_addr", {2'b0, imem_addr}, 32'h0010_0000);
`ifdef FETCH_PERF_EN
    check("rst.fetch_count", fetch_count, 32'd0);
    check("rst.stall_count", stall_count, 32'd0);
`endif

    // first fetch
    reset = 1'b1;
    step();
    check_ifid("f0", 32'h0040_0004, 32'h2008_0005, 32'h0040_0004, 1'b1);
    step();
    check_ifid("f1", 32'h0040_0008, inst_of(32'h0040_0004), 32'h0040_0008, 1'b1);

    // stall three edges at 0x00400008
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_ifid("stall", 32'h0040_0008, inst_of(32'h0040_0004), 32'h0040_0008, 1'b1);
    end
    stall = 1'b0;
    step();
    check_ifid("resume", 32'h0040_000C, inst_of(32'h0040_0008), 32'h0040_000C, 1'b1);

    // redirect + flush, unaligned target
    redirect_valid = 1'b1; redirect_pc = 32'h0040_0023; flush = 1'b1;
    step();
    check_ifid("redir_flush", 32'h0040_0020, 32'h0, 32'h0, 1'b0);
    redirect_valid = 1'b0; flush = 1'b0;
    step();
    check_ifid("target", 32'h0040_0024, inst_of(32'h0040_0020), 32'h0040_0024, 1'b1);

    // redirect + stall: PC moves, IF/ID holds
    redirect_valid = 1'b1; redirect_pc = 32'h0040_0100; stall = 1'b1;
    step();
    check_ifid("redir_stall", 32'h0040_0100, inst_of(32'h0040_0020), 32'h0040_0024, 1'b1);
    redirect_valid = 1'b0; flush = 1'b1;
    step();
    check_ifid("flush_stall", 32'h0040_0100, 32'h0, 32'h0, 1'b0);
    stall = 1'b0; flush = 1'b0;
    step();
    check_ifid("after_fs", 32'h0040_0104, inst_of(32'h0040_0100), 32'h0040_0104, 1'b1);

    // wrap at top of address space
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    step();
    check("wrap.pc_top", pc, 32'hFFFF_FFFC);
    check("wrap.imem_addr", {2'b0, imem_addr}, 32'h3FFF_FFFF);
    redirect_valid = 1'b0;
    step();
    check_ifid("wrap", 32'h0000_0000, inst_of(32'hFFFF_FFFC), 32'h0000_0000, 1'b1);

    // reset mid-stall overrides stall, flush and redirect
    stall = 1'b1;
    step();
    reset = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0000_1234; flush = 1'b1;
    step();
    check_ifid("mid_rst", 32'h0040_0000, 32'h0, 32'h0, 1'b0);
    check("mid_rst.imem_addr", {2'b0, imem_addr}, 32'h0010_0000);
`ifdef FETCH_PERF_EN
    check("mid_rst.fetch_count", fetch_count, 32'd0);
    check("mid_rst.stall_count", stall_count, 32'd0);
`endif

    // 10 free edges, 4 stall edges, 1 flush edge
    reset = 1'b1; stall = 1'b0; flush = 1'b0; redirect_valid = 1'b0;
    for (int i = 0; i < 10; i++) step();
    check("perf.pc_free", pc, 32'h0040_0028);
    stall = 1'b1;
    for (int i = 0; i < 4; i++) step();
    stall = 1'b0; flush = 1'b1;
    step();
    flush = 1'b0;
    check_ifid("perf.flush", 32'h0040_002C, 32'h0, 32'h0, 1'b0);
`ifdef FETCH_PERF_EN
    check("perf.fetch_count", fetch_count, 32'd10);
    check("perf.stall_count", stall_count, 32'd4);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
